id_decode_ctrl: RTL and testbench
=================================

# id_decode_ctrl

Registered decode-control stage for the RV32I pipeline. It replaces the purely combinational ID controller with a valid/ready-handshaked ID/EX control register. It adds a parametrised load-use scoreboard that inserts bubbles, a flush path for branch redirects, an illegal-instruction flag and a saturating stall counter. It sits between the IF/ID register and the EX stage.

## Interface
- LOAD_LAT, 1, cycles after a load leaves ID/EX before its data is forwardable. Legal range 1..4.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  the IF/ID instruction is valid.
- instr  in  32  the instruction word.
- in_ready  out  1  ID accepts the instruction this cycle.
- flush  in  1  branch/jump redirect; squashes ID/EX and the incoming instruction.
- ex_ready  in  1  EX accepts the ID/EX contents this cycle.
- out_valid  out  1  the ID/EX control bundle is valid.
- branch, jump, mem_read, mem_to_reg, alu_src, reg_write  out  1 each  registered control bits.
- mem_write  out  2  store size: 00 idle, 01 byte, 10 half, 11 word.
- rd  out  5  destination register.
- illegal  out  1  the decoded instruction is illegal.
- stall_cycles  out  CNT_W  saturating count of hazard-stall cycles.

## Operation
- Fields: opcode = instr[6:0]; rd = instr[11:7]; funct3 = instr[14:12]; rs1 = instr[19:15]; rs2 = instr[24:20]; funct7 = instr[31:25].
- Decode table, listed as {branch, jump, mem_read, mem_to_reg, alu_src, reg_write}:
  - LUI: 000011
  - AUIPC: 000011
  - JAL: 010011
  - JALR: 010011
  - BRANCH: 100000
  - LOAD: 001111
  - STORE: 000010
  - OP_IMM: 000011
  - OP: 000001
- mem_write: set only for STORE. funct3 000 gives 01, 001 gives 10, 010 gives 11.
- Illegal instructions:
  - unknown opcode;
  - STORE with funct3 > 2;
  - LOAD with funct3 of 011, 110 or 111;
  - OP with funct7 other than 0x00 or 0x20.
- An illegal instruction gives illegal=1 with all other controls 0 and rd=0. It still flows through with out_valid=1.
- Source usage:
  - rs1 is used by JALR, BRANCH, LOAD, STORE, OP_IMM and OP.
  - rs2 is used by BRANCH, STORE and OP.
  - A source equal to x0 never causes a hazard.
- Pending loads:
  - ID/EX itself holds a pending load when out_valid & mem_read & rd≠0.
  - The scoreboard has LOAD_LAT−1 slots of {valid, rd} and no slots when LOAD_LAT=1.
  - The scoreboard shifts only on cycles with ex_ready=1. Slot 0 takes the departing ID/EX load if one fires (out_valid & ex_ready & mem_read & rd≠0); otherwise slot 0 becomes invalid. The oldest slot drops off.
- hazard = in_valid & (a used source matches a pending load rd in ID/EX or in any valid scoreboard slot).
- in_ready = ~flush & ~hazard & (~out_valid | ex_ready).
- ID/EX register update, highest priority first:
  1. flush: out_valid becomes 0 and the controls become 0.
  2. in_valid & in_ready: the register loads the decoded bundle and out_valid becomes 1.
  3. ex_ready: out_valid becomes 0 and the controls become 0 (bubble).
  4. Otherwise: the register holds its contents.
- Whenever out_valid=0, all control outputs, rd and illegal are 0.
- flush never clears the scoreboard, because scoreboard entries are older than the redirect.
- stall_cycles increments on every cycle with hazard & ~flush and saturates at 2^CNT_W−1.

## Timing
- Reset (asynchronous, immediate) sets:
  - out_valid and every control output, rd and illegal to 0;
  - every scoreboard slot to invalid;
  - stall_cycles to 0.
- in_ready is combinational and is 0 while rst is asserted.
- Latency: an instruction accepted in cycle N appears on out_valid in cycle N+1.
- Backpressure: while out_valid=1 and ex_ready=0, all outputs hold stable and the scoreboard does not age.
- Load-use: a dependent instruction directly after a load sees LOAD_LAT bubbles when ex_ready is held at 1.
- Simultaneous flush and in_valid: the instruction is not accepted (in_ready=0) and must be re-presented by IF.
- Simultaneous flush and hazard: no stall count for that cycle.
- If reset asserts mid-stall or mid-backpressure, all state clears at once. The first cycle after release is free of hazards.

## Test plan
- Reset and decode, ex_ready=1: assert rst mid-stream, then release. After release present 0x0020A023 (SW x2,0(x1)).
  - Required next cycle: out_valid=1, mem_write=11, alu_src=1, reg_write=0, illegal=0.
  - Also sweep one encoding of each opcode against the decode table.
- Load-use, LOAD_LAT=1: 0x0000A283 (LW x5,0(x1)) then 0x00028333 (ADD x6,x5,x0).
  - Required: in_ready=0 for exactly one cycle and one bubble with out_valid=0.
  - ADD reaches out_valid two cycles after LW; stall_cycles=1.
  - Rerun with LOAD_LAT=3: three bubbles and stall_cycles=3.
- rd=x0 load: 0x0000A003 (LW x0) followed by ADD using x0. Required: no bubble and stall_cycles stays 0.
- Backpressure: LW x5 in ID/EX, ADD x6,x5 waiting, ex_ready=0 for 5 cycles.
  - Required: outputs stable and in_ready=0 during the hold.
  - Required: stall_cycles advances by 5, then one more bubble after ex_ready rises (LOAD_LAT=1).
- Flush: flush=1 with in_valid=1 and out_valid=1 while ex_ready=0.
  - Required next cycle: out_valid=0 and the instruction not accepted.
  - Required: scoreboard contents preserved, so a later dependent instruction still stalls.
- Illegal: instr=0x0000007F, then 0x0000B023 (STORE funct3=011).
  - Required for each: out_valid=1, illegal=1 and all other controls 0.
- Saturation: with CNT_W=4, hold a hazard for 20 cycles. Required: stall_cycles=15.

Source files
------------

// File: rtl/id_decode_ctrl.sv
// ID/EX control register for the RV32I pipeline: decode, load-use scoreboard,
// redirect flush, illegal-instruction flag and a saturating stall counter.
module id_decode_ctrl #(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [31:0]      instr,
  output logic             in_ready,
  input  logic             flush,
  input  logic             ex_ready,
  output logic             out_valid,
  output logic             branch,
  output logic             jump,
  output logic             mem_read,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             reg_write,
  output logic [1:0]       mem_write,
  output logic [4:0]       rd,
  output logic             illegal,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       mem_read;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] mem_write;
    logic [4:0] rd;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode(input logic [31:0] ins);
    ctrl_t c;
    c = '0;
    case (ins[6:0])
      OPC_LUI, OPC_AUIPC, OPC_OP_IMM: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OPC_JAL, OPC_JALR: begin
        c.jump      = 1'b1;
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
      end
      OPC_BRANCH: c.branch = 1'b1;
      OPC_LOAD: begin
        if (ins[14:12] == 3'b011 || ins[14:13] == 2'b11) begin
          c.illegal = 1'b1;
        end else begin
          c.mem_read   = 1'b1;
          c.mem_to_reg = 1'b1;
          c.alu_src    = 1'b1;
          c.reg_write  = 1'b1;
        end
      end
      OPC_STORE: begin
        case (ins[14:12])
          3'b000:  c.mem_write = 2'b01;
          3'b001:  c.mem_write = 2'b10;
          3'b010:  c.mem_write = 2'b11;
          default: c.illegal   = 1'b1;
        endcase
        c.alu_src = ~c.illegal;
      end
      OPC_OP: begin
        if (ins[31:25] == 7'h00 || ins[31:25] == 7'h20) c.reg_write = 1'b1;
        else c.illegal = 1'b1;
      end
      default: c.illegal = 1'b1;
    endcase
    // Illegal words leave only the flag set so they cannot create a pending load.
    c.rd = c.illegal ? 5'd0 : ins[11:7];
    return c;
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return op inside {OPC_JALR, OPC_BRANCH, OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OPC_BRANCH, OPC_STORE, OPC_OP};
  endfunction

  function automatic logic src_match(input logic used, input logic [4:0] rs,
                                     input logic [4:0] dst);
    return used && (rs != 5'd0) && (rs == dst);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Stage p0: decode and hazard detection on the IF/ID word
  logic [4:0] rs1_p0;
  logic [4:0] rs2_p0;
  logic       use1_p0;
  logic       use2_p0;
  ctrl_t      dec_p0;
  ctrl_t      ctrl_p1;
  logic       vld_p1;
  logic [CNT_W-1:0] stall_q;
  logic       idex_hit;
  logic       sb_hit;
  logic       hazard;
  logic       accept;
  logic       fire_load;

  assign rs1_p0  = instr[19:15];
  assign rs2_p0  = instr[24:20];
  assign use1_p0 = uses_rs1(instr[6:0]);
  assign use2_p0 = uses_rs2(instr[6:0]);
  assign dec_p0  = decode(instr);

  assign idex_hit = vld_p1 && ctrl_p1.mem_read && (ctrl_p1.rd != 5'd0) &&
                    (src_match(use1_p0, rs1_p0, ctrl_p1.rd) ||
                     src_match(use2_p0, rs2_p0, ctrl_p1.rd));
  assign hazard    = in_valid && (idex_hit || sb_hit);
  assign in_ready  = ~rst && ~flush && ~hazard && (~vld_p1 || ex_ready);
  assign accept    = in_valid && in_ready;
  assign fire_load = vld_p1 && ex_ready && ctrl_p1.mem_read && (ctrl_p1.rd != 5'd0);

  // Loads that have left ID/EX but whose data is not yet forwardable.
  if (LOAD_LAT > 1) begin : g_sb
    localparam int N = LOAD_LAT - 1;
    logic [N-1:0] sb_vld;
    logic [4:0]   sb_rd [N];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        sb_vld <= '0;
      end else if (ex_ready) begin
        sb_vld[0] <= fire_load;
        for (int i = 1; i < N; i++) sb_vld[i] <= sb_vld[i-1];
      end
    end

    always_ff @(posedge clk) begin
      if (ex_ready) begin
        sb_rd[0] <= ctrl_p1.rd;
        for (int i = 1; i < N; i++) sb_rd[i] <= sb_rd[i-1];
      end
    end

    always_comb begin
      sb_hit = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (sb_vld[i] && (src_match(use1_p0, rs1_p0, sb_rd[i]) ||
                          src_match(use2_p0, rs2_p0, sb_rd[i])))
          sb_hit = 1'b1;
      end
    end
  end else begin : g_no_sb
    assign sb_hit = 1'b0;
  end

  // Stage p1: ID/EX control register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (flush) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end else if (accept) begin
      vld_p1  <= 1'b1;
      ctrl_p1 <= dec_p0;
    end else if (ex_ready) begin
      vld_p1  <= 1'b0;
      ctrl_p1 <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_q <= '0;
    else if (hazard && !flush) stall_q <= sat_inc(stall_q);
  end

  assign out_valid    = vld_p1;
  assign branch       = ctrl_p1.branch;
  assign jump         = ctrl_p1.jump;
  assign mem_read     = ctrl_p1.mem_read;
  assign mem_to_reg   = ctrl_p1.mem_to_reg;
  assign alu_src      = ctrl_p1.alu_src;
  assign reg_write    = ctrl_p1.reg_write;
  assign mem_write    = ctrl_p1.mem_write;
  assign rd           = ctrl_p1.rd;
  assign illegal      = ctrl_p1.illegal;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_id_decode_ctrl.sv
// Directed bench for id_decode_ctrl: three instances (LOAD_LAT=1, LOAD_LAT=3,
// CNT_W=4) share one stimulus stream; each scenario starts from reset.
module tb_id_decode_ctrl;

  localparam logic [31:0] LW_X5     = 32'h0000A283;
  localparam logic [31:0] LW_X0     = 32'h0000A003;
  localparam logic [31:0] ADD_X6_X5 = 32'h00028333;
  localparam logic [31:0] ADD_X6_X0 = 32'h00000333;
  localparam logic [31:0] ADDI_X7   = 32'h00100393;
  localparam logic [31:0] SW_X2_X1  = 32'h0020A023;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] instr = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b0;

  wire         a_rdy, a_ov, a_ill, c_rdy, c_ov, c_ill, s_rdy, s_ov, s_ill;
  wire [5:0]   a_ctl, c_ctl, s_ctl;
  wire [1:0]   a_mw, c_mw, s_mw;
  wire [4:0]   a_rd, c_rd, s_rd;
  wire [31:0]  a_stall, c_stall;
  wire [3:0]   s_stall;

  int errors = 0;
  int checks = 0;

  id_decode_ctrl #(.LOAD_LAT(1), .CNT_W(32)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(a_rdy),
    .flush(flush), .ex_ready(ex_ready), .out_valid(a_ov),
    .branch(a_ctl[5]), .jump(a_ctl[4]), .mem_read(a_ctl[3]), .mem_to_reg(a_ctl[2]),
    .alu_src(a_ctl[1]), .reg_write(a_ctl[0]), .mem_write(a_mw), .rd(a_rd),
    .illegal(a_ill), .stall_cycles(a_stall));

  id_decode_ctrl #(.LOAD_LAT(3), .CNT_W(32)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(c_rdy),
    .flush(flush), .ex_ready(ex_ready), .out_valid(c_ov),
    .branch(c_ctl[5]), .jump(c_ctl[4]), .mem_read(c_ctl[3]), .mem_to_reg(c_ctl[2]),
    .alu_src(c_ctl[1]), .reg_write(c_ctl[0]), .mem_write(c_mw), .rd(c_rd),
    .illegal(c_ill), .stall_cycles(c_stall));

  id_decode_ctrl #(.LOAD_LAT(1), .CNT_W(4)) u_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .instr(instr), .in_ready(s_rdy),
    .flush(flush), .ex_ready(ex_ready), .out_valid(s_ov),
    .branch(s_ctl[5]), .jump(s_ctl[4]), .mem_read(s_ctl[3]), .mem_to_reg(s_ctl[2]),
    .alu_src(s_ctl[1]), .reg_write(s_ctl[0]), .mem_write(s_mw), .rd(s_rd),
    .illegal(s_ill), .stall_cycles(s_stall));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic f, input logic er);
    in_valid = v;
    instr    = i;
    flush    = f;
    ex_ready = er;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    tick();
    drive(1'b1, ADD_X6_X5, 1'b0, 1'b1);
    tick();
    checks++; if (c_stall !== 32'd1) begin errors++; $display("FAIL pre_rst_stall: got %0d want 1", c_stall); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({a_ov, a_ctl, a_mw, a_rd, a_ill} !== 15'h0) begin errors++; $display("FAIL rst_outputs: got %h want 0", {a_ov, a_ctl, a_mw, a_rd, a_ill}); end
    checks++; if (a_stall !== 32'd0) begin errors++; $display("FAIL rst_stall_a: got %0d want 0", a_stall); end
    checks++; if (c_stall !== 32'd0) begin errors++; $display("FAIL rst_stall_c: got %0d want 0", c_stall); end
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b want 0", a_rdy); end
    tick();
    rst = 1'b0;
    #1;
    checks++; if (c_rdy !== 1'b1) begin errors++; $display("FAIL rst_sb_clear: got %b want 1", c_rdy); end
    tick();
    checks++; if ({c_ov, c_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL rst_first_accept: got %h want %h", {c_ov, c_rd}, {1'b1, 5'd6}); end
    drive(1'b1, SW_X2_X1, 1'b0, 1'b1);
    tick();
    checks++; if ({a_ov, a_ctl, a_mw, a_ill} !== {1'b1, 6'b000010, 2'b11, 1'b0}) begin
      errors++; $display("FAIL rst_sw_decode: got %h want %h", {a_ov, a_ctl, a_mw, a_ill}, {1'b1, 6'b000010, 2'b11, 1'b0});
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_decode();
    logic [31:0] tv_i [11];
    logic [5:0]  tv_c [11];
    logic [1:0]  tv_m [11];
    logic [4:0]  tv_r [11];
    tv_i = '{32'h123450B7, 32'h00001117, 32'h008000EF, 32'h00008067, 32'h00208063, 32'h00412183,
             32'h00208023, 32'h00209023, 32'h0020A023, 32'h00500213, 32'h402082B3};
    tv_c = '{6'b000011, 6'b000011, 6'b010011, 6'b010011, 6'b100000, 6'b001111,
             6'b000010, 6'b000010, 6'b000010, 6'b000011, 6'b000001};
    tv_m = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b00};
    tv_r = '{5'd1, 5'd2, 5'd1, 5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd4, 5'd5};
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, tv_i[i], 1'b0, 1'b1);
      tick();
      checks++;
      if ({a_ov, a_ctl, a_mw, a_rd, a_ill} !== {1'b1, tv_c[i], tv_m[i], tv_r[i], 1'b0}) begin
        errors++;
        $display("FAIL decode[%0d] %h: got %h want %h", i, tv_i[i], {a_ov, a_ctl, a_mw, a_rd, a_ill},
                 {1'b1, tv_c[i], tv_m[i], tv_r[i], 1'b0});
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checks++; if ({a_ov, a_ctl, a_mw, a_rd, a_ill} !== 15'h0) begin errors++; $display("FAIL drain_bubble: got %h want 0", {a_ov, a_ctl, a_mw, a_rd, a_ill}); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    tick();
    checks++; if ({a_ov, a_ctl, a_rd} !== {1'b1, 6'b001111, 5'd5}) begin errors++; $display("FAIL lu_lw: got %h want %h", {a_ov, a_ctl, a_rd}, {1'b1, 6'b001111, 5'd5}); end
    drive(1'b1, ADD_X6_X5, 1'b0, 1'b1);
    #1;
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL lu_stall_a: got %b want 0", a_rdy); end
    for (int k = 0; k < 3; k++) begin
      checks++; if (c_rdy !== 1'b0) begin errors++; $display("FAIL lu3_stall[%0d]: got %b want 0", k, c_rdy); end
      tick();
      checks++; if (c_ov !== 1'b0) begin errors++; $display("FAIL lu3_bubble[%0d]: got %b want 0", k, c_ov); end
      if (k == 0) begin
        checks++; if ({a_ov, a_rdy} !== 2'b01) begin errors++; $display("FAIL lu_bubble_a: got %b want 01", {a_ov, a_rdy}); end
      end else if (k == 1) begin
        checks++; if ({a_ov, a_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu_add_a: got %h want %h", {a_ov, a_rd}, {1'b1, 5'd6}); end
        checks++; if (a_stall !== 32'd1) begin errors++; $display("FAIL lu_stall_cnt_a: got %0d want 1", a_stall); end
      end
    end
    checks++; if (c_rdy !== 1'b1) begin errors++; $display("FAIL lu3_release: got %b want 1", c_rdy); end
    tick();
    checks++; if ({c_ov, c_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu3_add: got %h want %h", {c_ov, c_rd}, {1'b1, 5'd6}); end
    checks++; if (c_stall !== 32'd3) begin errors++; $display("FAIL lu3_stall_cnt: got %0d want 3", c_stall); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_rd_x0();
    do_reset();
    drive(1'b1, LW_X0, 1'b0, 1'b1);
    tick();
    checks++; if ({a_ov, a_ctl, a_rd} !== {1'b1, 6'b001111, 5'd0}) begin errors++; $display("FAIL x0_lw: got %h want %h", {a_ov, a_ctl, a_rd}, {1'b1, 6'b001111, 5'd0}); end
    drive(1'b1, ADD_X6_X0, 1'b0, 1'b1);
    #1;
    checks++; if ({a_rdy, c_rdy} !== 2'b11) begin errors++; $display("FAIL x0_no_stall: got %b want 11", {a_rdy, c_rdy}); end
    tick();
    checks++; if ({a_ov, a_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL x0_add: got %h want %h", {a_ov, a_rd}, {1'b1, 5'd6}); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checks++; if ({a_stall, c_stall} !== 64'd0) begin errors++; $display("FAIL x0_stall_cnt: got %0d/%0d want 0/0", a_stall, c_stall); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    tick();
    drive(1'b1, ADD_X6_X5, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready[%0d]: got %b want 0", k, a_rdy); end
      tick();
      checks++;
      if ({a_ov, a_ctl, a_mw, a_rd, a_ill} !== {1'b1, 6'b001111, 2'b00, 5'd5, 1'b0}) begin
        errors++; $display("FAIL bp_hold[%0d]: got %h want %h", k, {a_ov, a_ctl, a_mw, a_rd, a_ill}, {1'b1, 6'b001111, 2'b00, 5'd5, 1'b0});
      end
    end
    checks++; if (a_stall !== 32'd5) begin errors++; $display("FAIL bp_stall_a: got %0d want 5", a_stall); end
    checks++; if (c_stall !== 32'd5) begin errors++; $display("FAIL bp_stall_c: got %0d want 5", c_stall); end
    ex_ready = 1'b1;
    #1;
    checks++; if (a_rdy !== 1'b0) begin errors++; $display("FAIL bp_release_ready: got %b want 0", a_rdy); end
    tick();
    checks++; if ({a_ov, a_stall} !== {1'b0, 32'd6}) begin errors++; $display("FAIL bp_bubble: got ov=%b stall=%0d want ov=0 stall=6", a_ov, a_stall); end
    tick();
    checks++; if ({a_ov, a_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL bp_add: got %h want %h", {a_ov, a_rd}, {1'b1, 5'd6}); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (4) tick();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    tick();
    drive(1'b1, ADDI_X7, 1'b0, 1'b1);
    tick();
    checks++; if ({a_ov, a_rd} !== {1'b1, 5'd7}) begin errors++; $display("FAIL fl_addi: got %h want %h", {a_ov, a_rd}, {1'b1, 5'd7}); end
    drive(1'b1, ADD_X6_X5, 1'b1, 1'b0);
    #1;
    checks++; if ({a_rdy, c_rdy} !== 2'b00) begin errors++; $display("FAIL fl_ready: got %b want 00", {a_rdy, c_rdy}); end
    tick();
    checks++; if ({a_ov, a_ctl, a_rd, c_ov} !== 13'h0) begin errors++; $display("FAIL fl_squash: got %h want 0", {a_ov, a_ctl, a_rd, c_ov}); end
    checks++; if ({a_stall, c_stall} !== 64'd0) begin errors++; $display("FAIL fl_no_count: got %0d/%0d want 0/0", a_stall, c_stall); end
    drive(1'b1, ADD_X6_X5, 1'b0, 1'b1);
    #1;
    checks++; if ({a_rdy, c_rdy} !== 2'b10) begin errors++; $display("FAIL fl_sb_kept: got %b want 10", {a_rdy, c_rdy}); end
    tick();
    checks++; if ({c_ov, c_stall} !== {1'b0, 32'd1}) begin errors++; $display("FAIL fl_sb_stall: got ov=%b stall=%0d want ov=0 stall=1", c_ov, c_stall); end
    checks++; if ({a_ov, a_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL fl_reaccept: got %h want %h", {a_ov, a_rd}, {1'b1, 5'd6}); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (3) tick();
  endtask

  task automatic test_illegal();
    logic [31:0] tv_i [4];
    tv_i = '{32'h0000007F, 32'h0000B023, 32'h0000B283, 32'h02028333};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, tv_i[i], 1'b0, 1'b1);
      tick();
      checks++;
      if ({a_ov, a_ill, a_ctl, a_mw, a_rd} !== {1'b1, 1'b1, 6'b0, 2'b0, 5'd0}) begin
        errors++; $display("FAIL illegal[%0d] %h: got %h want %h", i, tv_i[i], {a_ov, a_ill, a_ctl, a_mw, a_rd}, {1'b1, 1'b1, 6'b0, 2'b0, 5'd0});
      end
    end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1'b1, LW_X5, 1'b0, 1'b1);
    tick();
    drive(1'b1, ADD_X6_X5, 1'b0, 1'b0);
    repeat (20) tick();
    checks++; if (s_stall !== 4'd15) begin errors++; $display("FAIL sat_cnt4: got %0d want 15", s_stall); end
    checks++; if (a_stall !== 32'd20) begin errors++; $display("FAIL sat_cnt32: got %0d want 20", a_stall); end
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    repeat (4) tick();
  endtask

  initial begin
    test_reset();
    test_decode();
    test_load_use();
    test_rd_x0();
    test_backpressure();
    test_flush();
    test_illegal();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
